truth_sweep: RTL and testbench

- Sequential exhaustive truth-table checker for small combinational lab circuits.
- Drives every input combination of an N_IN-input DUT in ascending binary order and holds each vector for HOLD cycles.
- Compares the DUT's 1-bit response against a latched expected truth table, then reports pass/fail, the mismatch count and the first failing vector.
- Replaces hand-written per-vector stimulus in the lab benches and sits between the bench controller and the DUT under test.

---
 rtl/truth_sweep.sv | 106 ++++++++++
 tb/tb_truth_sweep.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/truth_sweep.sv
// truth_sweep: exhaustive truth-table sweep of an N_IN-input DUT with mismatch count and first failing vector.
// Define TRUTH_SWEEP_STOP_ON_ERR_EN to abort the sweep at the first mismatch.
module truth_sweep #(
  parameter int N_IN = 4,
  parameter int HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_vec
);
  localparam int V = 2**N_IN;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN:0] ERR_ONE = (N_IN+1)'(1);
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d, fvec_q, fvec_d;
  logic [7:0] hold_q, hold_d;
  logic [V-1:0] tab_q, tab_d;
  logic [N_IN:0] err_q, err_d;
  logic pass_q, pass_d, fval_q, fval_d;
  logic sample, miss, last;
  assign sample = (state_q == RUN) && (hold_q == HOLD_LAST);
  assign miss = dut_out != tab_q[vec_q];
  assign last = vec_q == {N_IN{1'b1}};
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    hold_d = hold_q;
    tab_d = tab_q;
    err_d = err_q;
    pass_d = pass_q;
    fval_d = fval_q;
    fvec_d = fvec_q;
    if (state_q != RUN && start) begin
      state_d = RUN;
      tab_d = expected;
      err_d = '0;
      fval_d = 1'b0;
      fvec_d = '0;
      vec_d = '0;
      hold_d = '0;
      pass_d = 1'b0;
    end else if (state_q == RUN) begin
      hold_d = sample ? 8'd0 : hold_q + 8'd1;
      if (sample) begin
        if (miss) begin
          err_d = err_q + ERR_ONE;
          fval_d = 1'b1;
          fvec_d = fval_q ? fvec_q : vec_q;
        end
`ifdef TRUTH_SWEEP_STOP_ON_ERR_EN
        if (miss) begin
          state_d = DONE;
          pass_d = 1'b0;
          err_d = ERR_ONE;
          fvec_d = vec_q;
        end else
`endif
        if (last) begin
          state_d = DONE;
          pass_d = err_d == '0;
        end else begin
          vec_d = vec_q + VEC_ONE;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q <= '0;
      hold_q <= '0;
      tab_q <= '0;
      err_q <= '0;
      pass_q <= 1'b0;
      fval_q <= 1'b0;
      fvec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      hold_q <= hold_d;
      tab_q <= tab_d;
      err_q <= err_d;
      pass_q <= pass_d;
      fval_q <= fval_d;
      fvec_q <= fvec_d;
    end
  end
  assign vec = vec_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_err_valid = fval_q;
  assign first_err_vec = fvec_q;
endmodule

// File: tb/tb_truth_sweep.sv
// tb_truth_sweep: randomized and directed sweeps of truth_sweep against a table-counting reference model.
module tb_truth_sweep;
  localparam int N = 4;
  localparam int H = 2;
  localparam int V = 1 << N;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dut_out;
  logic [V-1:0] expected = '0, dtab = '0;
  logic [N-1:0] vec, first_err_vec;
  logic busy, done, pass, first_err_valid;
  logic [N:0] err_count;
  int checks = 0, errors = 0;

  truth_sweep #(.N_IN(N), .HOLD(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_out(dut_out),
    .vec(vec), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  always #5 clk = ~clk;
  assign dut_out = dtab[vec];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"}, int'(vec), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fval"}, int'(first_err_valid), 0);
    chk({tag, "_fvec"}, int'(first_err_vec), 0);
  endtask

  // poke_at >= 0 selects a busy cycle at which to pulse start (do_rst=0) or drop rst_n (do_rst=1)
  task automatic sweep(input logic [V-1:0] e, input logic [V-1:0] d, input int poke_at, input bit do_rst);
    int n, nerr, first, cyc, last_v;
    bit aborted;
    nerr = 0;
    first = -1;
    for (int i = 0; i < V; i++)
      if (e[i] != d[i]) begin
        nerr++;
        if (first < 0) first = i;
      end
    cyc = V * H;
    last_v = V - 1;
`ifdef TRUTH_SWEEP_STOP_ON_ERR_EN
    if (first >= 0) begin
      nerr = 1;
      cyc = (first + 1) * H;
      last_v = first;
    end
`endif
    dtab = d;
    expected = e;
    start = 1'b1;
    tick;
    start = 1'b0;
    expected = V'($urandom);
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
    chk("start_err", int'(err_count), 0);
    n = 0;
    aborted = 1'b0;
    while (busy && n < 4 * V * H && !aborted) begin
      chk("vec_seq", int'(vec), n / H);
      if (n == poke_at && do_rst) begin
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk_reset_vals("post_rst");
        aborted = 1'b1;
      end else begin
        if (n == poke_at) begin
          start = 1'b1;
          expected = ~e;
        end
        tick;
        start = 1'b0;
        n++;
      end
    end
    if (!aborted) begin
      chk("busy_cycles", n, cyc);
      chk("done", int'(done), 1);
      chk("pass", int'(pass), int'(nerr == 0));
      chk("err_count", int'(err_count), nerr);
      chk("first_valid", int'(first_err_valid), int'(first >= 0));
      if (first >= 0) chk("first_vec", int'(first_err_vec), first);
      chk("final_vec", int'(vec), last_v);
      repeat (3) tick;
      chk("hold_done", int'(done), 1);
      chk("hold_err", int'(err_count), nerr);
      chk("hold_vec", int'(vec), last_v);
    end
  endtask

  initial begin
    logic [V-1:0] par, maj, m;
    for (int i = 0; i < V; i++) begin
      par[i] = ^i[N-1:0];
      maj[i] = (i[0] & i[1]) | (i[0] & i[2]) | (i[1] & i[2]);
    end
    #1;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk_reset_vals("idle");
    sweep(par, par, -1, 1'b0);
    sweep(maj, maj, -1, 1'b0);
    sweep(maj, '0, -1, 1'b0);
    sweep({V{1'b1}}, '0, -1, 1'b0);
    sweep(par, par, 2 * H, 1'b0);
    sweep(maj, maj, 5 * H, 1'b1);
    sweep(maj, maj, -1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      m = V'($urandom) & V'($urandom) & V'($urandom);
      if (k == 0) m = '0;
      if (k == 1) m = {1'b1, {(V-1){1'b0}}};
      e_rand(m, k);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic e_rand(input logic [V-1:0] m, input int k);
    logic [V-1:0] e;
    e = V'($urandom);
    sweep(e, e ^ m, (k == 3) ? H * 7 : -1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
